// File: rtl/mem_arbiter.sv
// Memory arbiter between the fetch path, the load/store buffer and a
// byte-serial memory controller. It grants one requester at a time, issues a
// single-cycle enable and holds the request fields until the controller
// reports completion. Then it returns data with a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; all state and outputs hold while low
//   if_*            fetch requester (req/addr/flush in, done/data out)
//   lsb_*           load/store requester (req/load/opcode/addr/wdata in,
//                   done/rdata out)
//   io_buffer_full  IO output buffer full; blocks stores to IO space
//   mc_instr_*      controller fetch channel (en/addr out, valid/data in)
//   mc_lsb_*        controller LSB channel (en/load/opcode/addr/wdata out,
//                   valid/rdata in)
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] IO_BASE      = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_load,
    input  logic [5:0]  lsb_opcode,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic        io_buffer_full,
    output logic        mc_instr_en,
    output logic [31:0] mc_instr_addr,
    input  logic        mc_instr_valid,
    input  logic [31:0] mc_instr_data,
    output logic        mc_lsb_en,
    output logic        mc_lsb_load,
    output logic [5:0]  mc_lsb_opcode,
    output logic [31:0] mc_lsb_addr,
    output logic [31:0] mc_lsb_wdata,
    input  logic        mc_lsb_valid,
    input  logic [31:0] mc_lsb_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LSB, COOL} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_d;
    logic             discard, discard_d;

    logic        if_done_d, lsb_done_d, mc_instr_en_d, mc_lsb_en_d, mc_lsb_load_d;
    logic [31:0] if_data_d, lsb_rdata_d, mc_instr_addr_d, mc_lsb_addr_d, mc_lsb_wdata_d;
    logic [5:0]  mc_lsb_opcode_d;

    logic if_ok, lsb_ok, starving;

    // Stores into IO space wait while the IO buffer is full.
    assign lsb_ok   = lsb_req & ~(~lsb_load & (lsb_addr >= IO_BASE) & io_buffer_full);
    assign if_ok    = if_req & ~if_flush;
    assign starving = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            discard       <= 1'b0;
            if_done       <= 1'b0;
            if_data       <= '0;
            lsb_done      <= 1'b0;
            lsb_rdata     <= '0;
            mc_instr_en   <= 1'b0;
            mc_instr_addr <= '0;
            mc_lsb_en     <= 1'b0;
            mc_lsb_load   <= 1'b0;
            mc_lsb_opcode <= '0;
            mc_lsb_addr   <= '0;
            mc_lsb_wdata  <= '0;
        end else if (rdy) begin
            state         <= state_d;
            starve_cnt    <= starve_cnt_d;
            discard       <= discard_d;
            if_done       <= if_done_d;
            if_data       <= if_data_d;
            lsb_done      <= lsb_done_d;
            lsb_rdata     <= lsb_rdata_d;
            mc_instr_en   <= mc_instr_en_d;
            mc_instr_addr <= mc_instr_addr_d;
            mc_lsb_en     <= mc_lsb_en_d;
            mc_lsb_load   <= mc_lsb_load_d;
            mc_lsb_opcode <= mc_lsb_opcode_d;
            mc_lsb_addr   <= mc_lsb_addr_d;
            mc_lsb_wdata  <= mc_lsb_wdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state;
        starve_cnt_d    = starve_cnt;
        discard_d       = discard;
        if_done_d       = 1'b0;
        lsb_done_d      = 1'b0;
        mc_instr_en_d   = 1'b0;
        mc_lsb_en_d     = 1'b0;
        if_data_d       = if_data;
        lsb_rdata_d     = lsb_rdata;
        mc_instr_addr_d = mc_instr_addr;
        mc_lsb_load_d   = mc_lsb_load;
        mc_lsb_opcode_d = mc_lsb_opcode;
        mc_lsb_addr_d   = mc_lsb_addr;
        mc_lsb_wdata_d  = mc_lsb_wdata;

        unique case (state)
            IDLE: begin
                if (!if_req) begin
                    starve_cnt_d = '0;
                end
                if (if_ok && (starving || !lsb_ok)) begin
                    state_d         = BUSY_IF;
                    mc_instr_en_d   = 1'b1;
                    mc_instr_addr_d = if_addr;
                    starve_cnt_d    = '0;
                end else if (lsb_ok) begin
                    state_d         = BUSY_LSB;
                    mc_lsb_en_d     = 1'b1;
                    mc_lsb_load_d   = lsb_load;
                    mc_lsb_opcode_d = lsb_opcode;
                    mc_lsb_addr_d   = lsb_addr;
                    mc_lsb_wdata_d  = lsb_wdata;
                    if (if_req && !starving) begin
                        starve_cnt_d = starve_cnt + CNT_W'(1);
                    end
                end
            end
            BUSY_IF: begin
                if (mc_instr_valid) begin
                    // A flush arriving with the completion still drops the word.
                    if_data_d = mc_instr_data;
                    if_done_d = ~(discard | if_flush);
                    discard_d = 1'b0;
                    state_d   = COOL;
                end else if (if_flush) begin
                    discard_d = 1'b1;
                end
            end
            BUSY_LSB: begin
                if (mc_lsb_valid) begin
                    lsb_rdata_d = mc_lsb_rdata;
                    lsb_done_d  = 1'b1;
                    state_d     = COOL;
                end
            end
            COOL: begin
                state_d         = IDLE;
                mc_instr_addr_d = '0;
                mc_lsb_load_d   = 1'b0;
                mc_lsb_opcode_d = '0;
                mc_lsb_addr_d   = '0;
                mc_lsb_wdata_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req, if_flush;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req, lsb_load;
    logic [5:0]  lsb_opcode;
    logic [31:0] lsb_addr, lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        io_buffer_full;
    logic        mc_instr_en;
    logic [31:0] mc_instr_addr;
    logic        mc_instr_valid;
    logic [31:0] mc_instr_data;
    logic        mc_lsb_en, mc_lsb_load;
    logic [5:0]  mc_lsb_opcode;
    logic [31:0] mc_lsb_addr, mc_lsb_wdata;
    logic        mc_lsb_valid;
    logic [31:0] mc_lsb_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] OP_LW = 6'h02;
    localparam logic [5:0] OP_SB = 6'h08;

    mem_arbiter #(.STARVE_LIMIT(4), .IO_BASE(32'h0003_0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_load(lsb_load), .lsb_opcode(lsb_opcode),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .io_buffer_full(io_buffer_full),
        .mc_instr_en(mc_instr_en), .mc_instr_addr(mc_instr_addr),
        .mc_instr_valid(mc_instr_valid), .mc_instr_data(mc_instr_data),
        .mc_lsb_en(mc_lsb_en), .mc_lsb_load(mc_lsb_load),
        .mc_lsb_opcode(mc_lsb_opcode), .mc_lsb_addr(mc_lsb_addr),
        .mc_lsb_wdata(mc_lsb_wdata),
        .mc_lsb_valid(mc_lsb_valid), .mc_lsb_rdata(mc_lsb_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        lsb_req = 1'b0; lsb_load = 1'b0; lsb_opcode = '0; lsb_addr = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0;
        mc_instr_valid = 1'b0; mc_instr_data = '0;
        mc_lsb_valid = 1'b0; mc_lsb_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({if_done, lsb_done, mc_instr_en, mc_lsb_en, mc_lsb_load} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {if_done, lsb_done, mc_instr_en, mc_lsb_en, mc_lsb_load}); end
        checks++; if ({if_data, lsb_rdata, mc_instr_addr} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {if_data, lsb_rdata, mc_instr_addr}); end
        checks++; if ({mc_lsb_opcode, mc_lsb_addr, mc_lsb_wdata} !== 70'h0) begin errors++; $display("FAIL reset_lsb_fields: got %h want 0", {mc_lsb_opcode, mc_lsb_addr, mc_lsb_wdata}); end
    endtask

    task automatic test_fetch_only();
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        checks++; if (mc_instr_en !== 1'b1) begin errors++; $display("FAIL fetch_en: got %b want 1", mc_instr_en); end
        checks++; if (mc_instr_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h want 00000100", mc_instr_addr); end
        checks++; if (mc_lsb_en !== 1'b0) begin errors++; $display("FAIL fetch_no_lsb_en: got %b want 0", mc_lsb_en); end
        tick();
        checks++; if (mc_instr_en !== 1'b0) begin errors++; $display("FAIL fetch_en_single: got %b want 0", mc_instr_en); end
        checks++; if (mc_instr_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr_held: got %h want 00000100", mc_instr_addr); end
        mc_instr_valid = 1'b1; mc_instr_data = 32'h00C0_FFEE;
        tick();
        mc_instr_valid = 1'b0; if_req = 1'b0;
        checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %b want 1", if_done); end
        checks++; if (if_data !== 32'h00C0_FFEE) begin errors++; $display("FAIL fetch_data: got %h want 00c0ffee", if_data); end
        tick();
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse: got %b want 0", if_done); end
        checks++; if (mc_instr_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr_cleared: got %h want 0", mc_instr_addr); end
    endtask

    task automatic test_both_requests();
        do_reset();
        if_req = 1'b1; if_addr = 32'h500;
        lsb_req = 1'b1; lsb_load = 1'b1; lsb_opcode = OP_LW; lsb_addr = 32'h200;
        tick();
        checks++; if ({mc_lsb_en, mc_instr_en} !== 2'b10) begin errors++; $display("FAIL both_lsb_first: got %b want 10", {mc_lsb_en, mc_instr_en}); end
        checks++; if ({mc_lsb_load, mc_lsb_opcode, mc_lsb_addr} !== {1'b1, OP_LW, 32'h200}) begin errors++; $display("FAIL both_lsb_fields: got %h", {mc_lsb_load, mc_lsb_opcode, mc_lsb_addr}); end
        tick();
        mc_lsb_valid = 1'b1; mc_lsb_rdata = 32'hDEAD_BEEF;
        tick();
        mc_lsb_valid = 1'b0; lsb_req = 1'b0;
        checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL both_lsb_done: got %b want 1", lsb_done); end
        checks++; if (lsb_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL both_lsb_rdata: got %h want deadbeef", lsb_rdata); end
        checks++; if (mc_instr_en !== 1'b0) begin errors++; $display("FAIL both_no_grant_cool: got %b want 0", mc_instr_en); end
        tick();
        checks++; if (mc_instr_en !== 1'b0) begin errors++; $display("FAIL both_no_grant_early: got %b want 0", mc_instr_en); end
        tick();
        checks++; if (mc_instr_en !== 1'b1 || mc_instr_addr !== 32'h500) begin errors++; $display("FAIL both_fetch_grant: got en=%b addr=%h want en=1 addr=00000500", mc_instr_en, mc_instr_addr); end
        tick();
        mc_instr_valid = 1'b1; mc_instr_data = 32'h1234_5678;
        tick();
        mc_instr_valid = 1'b0; if_req = 1'b0;
        checks++; if (if_done !== 1'b1 || if_data !== 32'h1234_5678) begin errors++; $display("FAIL both_fetch_done: got done=%b data=%h want 1 12345678", if_done, if_data); end
        tick();
    endtask

    task automatic test_starvation();
        do_reset();
        if_req = 1'b1; if_addr = 32'h600;
        lsb_req = 1'b1; lsb_load = 1'b0; lsb_opcode = OP_SB; lsb_addr = 32'h1000; lsb_wdata = 32'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({mc_lsb_en, mc_instr_en} !== 2'b10) begin errors++; $display("FAIL starve_lsb_grant%0d: got %b want 10", i, {mc_lsb_en, mc_instr_en}); end
            tick();
            mc_lsb_valid = 1'b1;
            tick();
            mc_lsb_valid = 1'b0;
            tick();
        end
        tick();
        checks++; if ({mc_lsb_en, mc_instr_en} !== 2'b01) begin errors++; $display("FAIL starve_fetch_forced: got %b want 01", {mc_lsb_en, mc_instr_en}); end
        tick();
        mc_instr_valid = 1'b1; mc_instr_data = 32'hAAAA_0001;
        tick();
        mc_instr_valid = 1'b0; if_addr = 32'h604;
        tick();
        tick();
        checks++; if ({mc_lsb_en, mc_instr_en} !== 2'b10) begin errors++; $display("FAIL starve_cnt_cleared: got %b want 10", {mc_lsb_en, mc_instr_en}); end
        tick();
        mc_lsb_valid = 1'b1;
        tick();
        mc_lsb_valid = 1'b0; lsb_req = 1'b0; if_req = 1'b0;
        tick();
    endtask

    task automatic test_io_backpressure();
        do_reset();
        if_req = 1'b1; if_addr = 32'h700;
        lsb_req = 1'b1; lsb_load = 1'b0; lsb_opcode = OP_SB; lsb_addr = 32'h0003_0000; lsb_wdata = 32'hA5;
        io_buffer_full = 1'b1;
        tick();
        checks++; if ({mc_lsb_en, mc_instr_en} !== 2'b01) begin errors++; $display("FAIL io_fetch_first: got %b want 01", {mc_lsb_en, mc_instr_en}); end
        tick();
        mc_instr_valid = 1'b1;
        tick();
        mc_instr_valid = 1'b0; if_req = 1'b0;
        tick();
        tick();
        checks++; if (mc_lsb_en !== 1'b0) begin errors++; $display("FAIL io_store_blocked: got %b want 0", mc_lsb_en); end
        io_buffer_full = 1'b0;
        tick();
        checks++; if (mc_lsb_en !== 1'b1) begin errors++; $display("FAIL io_store_issue: got %b want 1", mc_lsb_en); end
        checks++; if ({mc_lsb_load, mc_lsb_opcode, mc_lsb_addr, mc_lsb_wdata} !== {1'b0, OP_SB, 32'h0003_0000, 32'hA5}) begin errors++; $display("FAIL io_store_fields: got %h", {mc_lsb_load, mc_lsb_opcode, mc_lsb_addr, mc_lsb_wdata}); end
        tick();
        tick();
        checks++; if (mc_lsb_en !== 1'b0 || mc_lsb_wdata !== 32'hA5) begin errors++; $display("FAIL io_wdata_held: got en=%b wdata=%h want 0 000000a5", mc_lsb_en, mc_lsb_wdata); end
        mc_lsb_valid = 1'b1;
        tick();
        mc_lsb_valid = 1'b0; lsb_req = 1'b0;
        checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL io_store_done: got %b want 1", lsb_done); end
        tick();
        checks++; if (mc_lsb_wdata !== 32'h0 || mc_lsb_opcode !== 6'h0) begin errors++; $display("FAIL io_fields_cleared: got wdata=%h op=%h want 0", mc_lsb_wdata, mc_lsb_opcode); end
        // One word below IO space is never blocked.
        lsb_req = 1'b1; lsb_addr = 32'h0002_FFFC; io_buffer_full = 1'b1;
        tick();
        checks++; if (mc_lsb_en !== 1'b1) begin errors++; $display("FAIL io_below_base: got %b want 1", mc_lsb_en); end
        tick();
        mc_lsb_valid = 1'b1;
        tick();
        mc_lsb_valid = 1'b0; lsb_req = 1'b0; io_buffer_full = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        if_req = 1'b1; if_addr = 32'h380; if_flush = 1'b1;
        tick();
        checks++; if (mc_instr_en !== 1'b0) begin errors++; $display("FAIL flush_idle_no_grant: got %b want 0", mc_instr_en); end
        if_flush = 1'b0;
        tick();
        checks++; if (mc_instr_en !== 1'b1) begin errors++; $display("FAIL flush_first_grant: got %b want 1", mc_instr_en); end
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        tick();
        if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h400;
        tick();
        mc_instr_valid = 1'b1; mc_instr_data = 32'h1111;
        tick();
        mc_instr_valid = 1'b0;
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b want 0", if_done); end
        tick();
        checks++; if (if_done !== 1'b0 || mc_instr_en !== 1'b0) begin errors++; $display("FAIL flush_cool: got done=%b en=%b want 0 0", if_done, mc_instr_en); end
        tick();
        checks++; if (mc_instr_en !== 1'b1 || mc_instr_addr !== 32'h400) begin errors++; $display("FAIL flush_next_fetch: got en=%b addr=%h want 1 00000400", mc_instr_en, mc_instr_addr); end
        tick();
        mc_instr_valid = 1'b1; mc_instr_data = 32'h2222;
        tick();
        mc_instr_valid = 1'b0; if_req = 1'b0;
        checks++; if (if_done !== 1'b1 || if_data !== 32'h2222) begin errors++; $display("FAIL flush_next_done: got done=%b data=%h want 1 00002222", if_done, if_data); end
        tick();
    endtask

    task automatic test_rdy_and_reset();
        do_reset();
        lsb_req = 1'b1; lsb_load = 1'b1; lsb_opcode = OP_LW; lsb_addr = 32'h800;
        tick();
        checks++; if (mc_lsb_en !== 1'b1) begin errors++; $display("FAIL rdy_grant: got %b want 1", mc_lsb_en); end
        tick();
        rdy = 1'b0; mc_lsb_valid = 1'b1; mc_lsb_rdata = 32'hBAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (lsb_done !== 1'b0 || lsb_rdata !== 32'h0 || mc_lsb_addr !== 32'h800) begin errors++; $display("FAIL rdy_frozen%0d: got done=%b rdata=%h addr=%h want 0 0 00000800", i, lsb_done, lsb_rdata, mc_lsb_addr); end
        end
        rdy = 1'b1; mc_lsb_rdata = 32'h55AA;
        tick();
        mc_lsb_valid = 1'b0; lsb_req = 1'b0;
        checks++; if (lsb_done !== 1'b1 || lsb_rdata !== 32'h55AA) begin errors++; $display("FAIL rdy_resume_done: got done=%b rdata=%h want 1 000055aa", lsb_done, lsb_rdata); end
        tick();
        if_req = 1'b1; if_addr = 32'h900;
        tick();
        checks++; if (mc_instr_en !== 1'b1) begin errors++; $display("FAIL rst_pre_grant: got %b want 1", mc_instr_en); end
        tick();
        rst = 1'b1; if_req = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if ({mc_instr_en, if_done, lsb_done, mc_instr_addr, lsb_rdata, if_data} !== 99'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", {mc_instr_en, if_done, lsb_done, mc_instr_addr, lsb_rdata, if_data}); end
        // Stray valid in IDLE is ignored.
        mc_instr_valid = 1'b1; mc_instr_data = 32'hFFFF;
        tick();
        mc_instr_valid = 1'b0;
        checks++; if (if_done !== 1'b0 || if_data !== 32'h0) begin errors++; $display("FAIL rst_idle_valid_ignored: got done=%b data=%h want 0 0", if_done, if_data); end
        if_req = 1'b1; if_addr = 32'hA00;
        tick();
        checks++; if (mc_instr_en !== 1'b1 || mc_instr_addr !== 32'hA00) begin errors++; $display("FAIL rst_clean_grant: got en=%b addr=%h want 1 00000a00", mc_instr_en, mc_instr_addr); end
        tick();
        mc_instr_valid = 1'b1; mc_instr_data = 32'h3333;
        tick();
        mc_instr_valid = 1'b0; if_req = 1'b0;
        checks++; if (if_done !== 1'b1 || if_data !== 32'h3333) begin errors++; $display("FAIL rst_clean_done: got done=%b data=%h want 1 00003333", if_done, if_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_both_requests();
        test_starvation();
        test_io_backpressure();
        test_flush();
        test_rdy_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the fetch path (icache) and the load/store buffer on one side and the byte-serial memory controller on the other.
- Selects one requester at a time and issues a single-cycle enable pulse to the controller. It holds request fields stable until the controller's valid pulse, then returns data to the owner.
- Priority is LSB-first with starvation protection for fetch. It also handles fetch flush and IO-store backpressure.

Parameters:
STARVE_LIMIT, 4, consecutive LSB grants allowed while if_req is pending before fetch is forced ahead.
IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO space.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when 0 all state and outputs hold
if_req  in  1  fetch request, level, held until if_done or flush
if_addr  in  32  fetch address
if_flush  in  1  cancel current/pending fetch
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
lsb_req  in  1  LSB request, level, held until lsb_done
lsb_load  in  1  1=load, 0=store
lsb_opcode  in  6  load/store opcode
lsb_addr  in  32  access address
lsb_wdata  in  32  store data
lsb_done  out  1  one-cycle pulse
lsb_rdata  out  32  load result, extended by controller
io_buffer_full  in  1  IO output buffer full
mc_instr_en  out  1  fetch enable pulse to controller
mc_instr_addr  out  32  held fetch address
mc_instr_valid  in  1  controller fetch done
mc_instr_data  in  32  controller fetch word
mc_lsb_en  out  1  LSB enable pulse
mc_lsb_load  out  1  held load flag
mc_lsb_opcode  out  6  held opcode (held through completion; controller reads it at the end)
mc_lsb_addr  out  32  held address
mc_lsb_wdata  out  32  held store data
mc_lsb_valid  in  1  controller LSB done
mc_lsb_rdata  in  32  controller load data

Behaviour:
- Reset (rst=1 at posedge), all outputs 0:
  - state=IDLE, starve_cnt=0, discard=0.
  - if_done=0, lsb_done=0, if_data=0, lsb_rdata=0.
  - mc_*_en=0, all mc_* fields=0.
- Reset mid-transaction returns to IDLE immediately. The bench also resets the controller.
- rdy=0: no state, counter or output changes. Pulses are not re-emitted.
- States: IDLE, BUSY_IF, BUSY_LSB, COOL.
- lsb_ok = lsb_req & ~(~lsb_load & (lsb_addr >= IO_BASE) & io_buffer_full). IO stores wait; loads and non-IO stores are never blocked.
- if_ok = if_req & ~if_flush.
- IDLE grant order:
  - Fetch first if if_ok and starve_cnt == STARVE_LIMIT.
  - Else LSB if lsb_ok.
  - Else fetch if if_ok.
  - Else stay.
- On grant, next cycle:
  - Corresponding mc_*_en=1 for exactly one cycle.
  - Fields are latched from the requester and held until completion.
  - State becomes BUSY_IF or BUSY_LSB.
- starve_cnt:
  - On an LSB grant: +1 while if_req=1, saturating at STARVE_LIMIT.
  - On a fetch grant: cleared to 0.
  - When if_req=0 in IDLE: cleared to 0.
- BUSY_IF:
  - On mc_instr_valid: if_data<=mc_instr_data, and if_done pulses next cycle unless discard.
  - Then go to COOL.
  - if_flush in BUSY_IF sets discard=1; discard is cleared on leaving BUSY_IF.
- BUSY_LSB: on mc_lsb_valid, lsb_rdata<=mc_lsb_rdata and lsb_done pulses next cycle; go to COOL. Flush has no effect on LSB.
- COOL:
  - Lasts exactly one cycle, matching the controller's post-completion stall.
  - Pulses are deasserted; go to IDLE. No grant is possible in COOL.
  - Clear mc_* fields to 0 on the COOL→IDLE transition.
- Latency:
  - Request seen at IDLE edge N → enable high in cycle N+1.
  - Done pulse one cycle after valid.
  - Next grant no earlier than two cycles after valid.
- Simultaneous events:
  - if_flush with if_req in IDLE means no fetch grant that cycle.
  - Both requests present: LSB wins unless starving.
- Valid while in IDLE or COOL is ignored (protocol error). Enables are never asserted outside the issue cycle.

Test Plan:
1. Fetch only, if_addr=0x100, controller returns 0x00C0FFEE → single mc_instr_en pulse; mc_instr_addr=0x100 until valid; if_done pulse with if_data=0x00C0FFEE one cycle after valid.
2. if_req and lsb_req (load, LW, addr 0x200) asserted together → LSB granted first; fetch granted 2 cycles after mc_lsb_valid; lsb_rdata matches controller data.
3. lsb_req held continuously with if_req pending, STARVE_LIMIT=4 → 4 LSB grants, then a fetch grant; starve_cnt=0 afterward.
4. Store SB to 0x30000 with io_buffer_full=1 and if_req pending → fetch is served, store is not issued; drop io_buffer_full → store issues with mc_lsb_wdata held.
5. if_flush pulsed mid BUSY_IF → no if_done on completion; next fetch (new address 0x400) proceeds normally after COOL.
6. rdy=0 for 3 cycles during BUSY_LSB, and rst asserted during BUSY_IF → state frozen, then a clean completion; reset zeroes all outputs and returns to IDLE.
